div_unit: RTL and testbench

Multi-cycle 32-bit integer divider in the execute stage; it produces the `alu_stallE` request that the hazard unit consumes. While a DIV/DIVU in E is being computed, it holds the pipeline. It presents a {remainder, quotient} result for HI/LO and honours flushes from the hazard unit. It keeps a finished result stable while the pipeline is frozen by a D-cache stall.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_step.sv | 28 ++
 rtl/div_unit.sv | 138 +++++++++++++
 tb/tb_div_unit.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: FSM states, cycle count
// and the field layout of the packed {HI, LO} result.
package div_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH;

  // Result layout: remainder in the upper half (HI), quotient in the lower (LO).
  localparam int HI_MSB = 2 * DIV_WIDTH - 1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int LO_MSB = DIV_WIDTH - 1;
  localparam int LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial-
// subtract the divisor, keep the difference and set the new quotient bit
// when there is no borrow. Purely combinational.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  // The shifted partial remainder needs one extra bit before the compare.
  logic [WIDTH:0] shifted;
  logic           no_borrow;

  // Trial subtraction; the difference always fits WIDTH bits when taken.
  always_comb begin
    shifted   = {rem_i, quo_i[WIDTH-1]};
    no_borrow = (shifted >= {1'b0, divisor_i});
    rem_o     = no_borrow ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
    quo_o     = {quo_i[WIDTH-2:0], no_borrow};
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle signed/unsigned divider for the execute stage. Holds the
// pipeline via alu_stallE while iterating, presents a registered
// {remainder, quotient} result in DONE and keeps it there while the
// D-cache freezes the pipeline. A flush aborts at any point.
module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_startE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   src_aE,
  input  logic [WIDTH-1:0]   src_bE,
  input  logic               flushE,
  input  logic               ext_stall,
  output logic               alu_stallE,
  output logic               div_ready,
  output logic [2*WIDTH-1:0] div_result
);

  localparam int CNT_W = $clog2(WIDTH);

  div_state_e         state_q,    state_d;
  logic [CNT_W-1:0]   cnt_q,      cnt_d;
  logic [WIDTH-1:0]   rem_q,      rem_d;
  logic [WIDTH-1:0]   quo_q,      quo_d;
  logic [WIDTH-1:0]   dvs_q,      dvs_d;
  logic               neg_quo_q,  neg_quo_d;
  logic               neg_rem_q,  neg_rem_d;
  logic [2*WIDTH-1:0] result_q,   result_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   step_rem, step_quo;
  logic [WIDTH-1:0]   fix_rem, fix_quo;
  logic               start_ok;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  // Operand magnitudes and sign-corrected final result of the last step.
  always_comb begin
    start_ok = div_startE & ~flushE;
    mag_a    = (div_signedE && src_aE[WIDTH-1]) ? -src_aE : src_aE;
    mag_b    = (div_signedE && src_bE[WIDTH-1]) ? -src_bE : src_bE;
    fix_quo  = neg_quo_q ? -step_quo : step_quo;
    fix_rem  = neg_rem_q ? -step_rem : step_rem;
  end

  // Next-state and datapath update for IDLE -> BUSY -> DONE.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;

    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          rem_d     = '0;
          quo_d     = mag_a;
          dvs_d     = mag_b;
          neg_quo_d = div_signedE & (src_aE[WIDTH-1] ^ src_bE[WIDTH-1]);
          neg_rem_d = div_signedE & src_aE[WIDTH-1];
          cnt_d     = '0;
          state_d   = BUSY;
        end
      end
      BUSY: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          result_d = {fix_rem, fix_quo};
          state_d  = DONE;
        end
      end
      DONE: begin
        if (!ext_stall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush aborts everything and never lets a result be committed.
    if (flushE) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  // Outputs: stall covers the accepting IDLE cycle plus all of BUSY.
  always_comb begin
    alu_stallE = ((state_q == IDLE) & start_ok) | (state_q == BUSY);
    div_ready  = (state_q == DONE);
    div_result = result_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed testbench for div_unit: hand-computed quotient/remainder
// vectors, stall length, flush, ext_stall hold, reset and back-to-back.
module tb_div_unit;
  import div_pkg::*;

  localparam int W = DIV_WIDTH;

  logic           clk = 1'b0;
  logic           rst;
  logic           div_startE;
  logic           div_signedE;
  logic [W-1:0]   src_aE;
  logic [W-1:0]   src_bE;
  logic           flushE;
  logic           ext_stall;
  logic           alu_stallE;
  logic           div_ready;
  logic [2*W-1:0] div_result;

  int n_checks = 0;
  int n_pass   = 0;

  div_unit #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .div_startE (div_startE),
    .div_signedE(div_signedE),
    .src_aE     (src_aE),
    .src_bE     (src_bE),
    .flushE     (flushE),
    .ext_stall  (ext_stall),
    .alu_stallE (alu_stallE),
    .div_ready  (div_ready),
    .div_result (div_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a divide in the current (IDLE) cycle and run until DONE; returns
  // with the DUT in its first DONE cycle and div_startE still high.
  task automatic run_div(input string tag, input logic sgn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp_hi,
                         input logic [W-1:0] exp_lo);
    int stall_cnt;
    logic [2*W-1:0] exp_res;
    exp_res = '0;
    exp_res[HI_MSB:HI_LSB] = exp_hi;
    exp_res[LO_MSB:LO_LSB] = exp_lo;
    div_startE  = 1'b1;
    div_signedE = sgn;
    src_aE      = a;
    src_bE      = b;
    #1;
    stall_cnt = alu_stallE ? 1 : 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      // Operands are sampled only at the start cycle.
      src_aE = ~a;
      src_bE = 32'h3;
      if (!alu_stallE) break;
      stall_cnt++;
    end
    check({tag, " stall_len"}, 64'(stall_cnt), 64'(DIV_CYCLES + 1));
    check({tag, " ready"},     64'(div_ready), 64'd1);
    check({tag, " result"},    div_result,     exp_res);
  endtask

  initial begin
    logic [2*W-1:0] held;

    rst = 1'b1; div_startE = 1'b0; div_signedE = 1'b0;
    src_aE = '0; src_bE = '0; flushE = 1'b0; ext_stall = 1'b0;
    tick(); tick();
    check("reset stall",  64'(alu_stallE), 64'd0);
    check("reset ready",  64'(div_ready),  64'd0);
    check("reset result", div_result,      64'd0);
    rst = 1'b0;
    tick();

    // DIVU 7/2, then leave E normally.
    run_div("divu 7/2", 1'b0, 32'd7, 32'd2, 32'd1, 32'd3);
    div_startE = 1'b0;
    tick();
    check("7/2 idle state", 64'(dut.state_q), 64'(IDLE));
    check("7/2 idle ready", 64'(div_ready),   64'd0);
    check("7/2 result held", div_result,      {32'd1, 32'd3});

    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    // Back-to-back: start held high straight through DONE into IDLE.
    tick();
    check("b2b idle state", 64'(dut.state_q), 64'(IDLE));
    run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    tick();
    run_div("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    tick();
    run_div("divu 5/0", 1'b0, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    tick();
    run_div("divu max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 32'hF, 32'h0FFF_FFFF);
    tick();
    div_startE = 1'b0;

    // Flush and start in the same IDLE cycle: flush wins.
    div_startE = 1'b1; flushE = 1'b1; src_aE = 32'd9; src_bE = 32'd3;
    #1;
    check("flush+start stall", 64'(alu_stallE), 64'd0);
    tick();
    check("flush+start state", 64'(dut.state_q), 64'(IDLE));
    div_startE = 1'b0; flushE = 1'b0;
    tick();

    // Flush at BUSY cycle 10.
    held = div_result;
    div_startE = 1'b1; div_signedE = 1'b0; src_aE = 32'd1000; src_bE = 32'd3;
    for (int i = 0; i < 10; i++) tick();
    check("pre-flush busy", 64'(alu_stallE), 64'd1);
    flushE = 1'b1;
    tick();
    flushE = 1'b0; div_startE = 1'b0;
    #1;
    check("flush state",  64'(dut.state_q), 64'(IDLE));
    check("flush stall",  64'(alu_stallE),  64'd0);
    check("flush ready",  64'(div_ready),   64'd0);
    check("flush result", div_result,       held);
    tick();
    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14);
    tick();
    div_startE = 1'b0;
    tick();

    // ext_stall high for 3 cycles from DONE entry.
    run_div("divu 1000/7", 1'b0, 32'd1000, 32'd7, 32'd6, 32'd142);
    held = div_result;
    ext_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 2) ext_stall = 1'b0;
      check($sformatf("xstall ready %0d", i),  64'(div_ready), 64'd1);
      check($sformatf("xstall result %0d", i), div_result,     held);
    end
    div_startE = 1'b0;
    tick();
    check("xstall release state", 64'(dut.state_q), 64'(IDLE));
    check("xstall release ready", 64'(div_ready),   64'd0);

    // Reset mid-BUSY.
    div_startE = 1'b1; src_aE = 32'd50; src_bE = 32'd5;
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1; div_startE = 1'b0;
    tick();
    rst = 1'b0;
    check("rst state",  64'(dut.state_q), 64'(IDLE));
    check("rst cnt",    64'(dut.cnt_q),   64'd0);
    check("rst stall",  64'(alu_stallE),  64'd0);
    check("rst ready",  64'(div_ready),   64'd0);
    check("rst result", div_result,       64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
